// File: rtl/divu4_pkg.sv
// Shared types and widths for the 4-bit sequential restoring divider.
//   W      : operand width
//   CNT_W  : bit-index counter width
//   PW     : partial-remainder width (one guard bit, so the subtract never underflows)
//   PRODW  : multiply-back product width
package divu4_pkg;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned PW    = W + 1;
    localparam int unsigned PRODW = 2 * W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/divu4_seq_chk_if.sv
// Request/result bundle for divu4_seq_chk.
//   start, dividend, divisor                              : requester -> divider
//   busy, done, quotient, remainder, div_by_zero, check_err : divider -> requester
interface divu4_seq_chk_if;
    import divu4_pkg::*;

    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         check_err;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, check_err
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, check_err
    );

endinterface

// File: rtl/divu4_seq_chk_mult4u_chk.sv
// Combinational 4x4 unsigned multiplier used for the divider's multiply-back check.
// Kept as its own cell so hardened mult4u variants can be dropped in.
//   a, b : unsigned operands
//   p_c  : 8-bit unsigned product (combinational)
module mult4u_chk
    import divu4_pkg::*;
(
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [PRODW-1:0] p_c
);

    // Shift-and-add array: one partial product per multiplier bit.
    always_comb begin
        p_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (b[i]) begin
                p_c = p_c + (PRODW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/divu4_seq_chk.sv
// Sequential unsigned 4-bit restoring divider (one quotient bit per cycle) with a
// multiply-back self-check: quotient*divisor + remainder must equal dividend.
//   clk, rst : clock, synchronous active-high reset
//   bus      : divu4_seq_chk_if.slave (start/operands in, busy/done/results/flags out)
// Parameters:
//   CHECK_EN  : 1 = run the CHECK state, 0 = skip it (check_err stays 0)
//   ZERO_QUOT : quotient returned on divide-by-zero
module divu4_seq_chk
    import divu4_pkg::*;
#(
    parameter bit           CHECK_EN  = 1'b1,
    parameter logic [W-1:0] ZERO_QUOT = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    divu4_seq_chk_if.slave  bus
);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [PW-1:0]      p_q, p_d;
    logic [W-1:0]       qacc_q, qacc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       quot_q, quot_d;
    logic [W-1:0]       rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic [PW-1:0]      trial_c;
    logic [PRODW-1:0]   prod_c;
    logic [PRODW-1:0]   sum_c;

    // Multiply-back of the stored result against the latched divisor.
    mult4u_chk u_mult (
        .a   (quot_q),
        .b   (b_q),
        .p_c (prod_c)
    );

    // A new request is taken in IDLE, and in DONE for back-to-back operation.
    assign accept_c = bus.start && ((state_q == IDLE) || (state_q == DONE));
    // Shift the next dividend bit (MSB first) into the partial remainder.
    assign trial_c  = {p_q[W-1:0], a_q[cnt_q]};
    assign sum_c    = prod_c + PRODW'(rem_q);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            qacc_q  <= qacc_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        qacc_d  = qacc_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        err_d   = err_q;

        case (state_q)
            IDLE: ;
            CALC: begin
                if (trial_c >= PW'(b_q)) begin
                    p_d            = trial_c - PW'(b_q);
                    qacc_d[cnt_q]  = 1'b1;
                end else begin
                    p_d            = trial_c;
                    qacc_d[cnt_q]  = 1'b0;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quot_d  = qacc_d;
                    rem_d   = p_d[W-1:0];
                    state_d = CHECK_EN ? CHECK : DONE;
                end
            end
            CHECK: begin
                if ((sum_c != PRODW'(a_q)) || (rem_q >= b_q)) begin
                    err_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the DONE -> IDLE return for back-to-back requests.
        if (accept_c) begin
            a_d   = bus.dividend;
            b_d   = bus.divisor;
            dbz_d = 1'b0;
            err_d = 1'b0;
            if (bus.divisor == '0) begin
                quot_d  = ZERO_QUOT;
                rem_d   = bus.dividend;
                dbz_d   = 1'b1;
                state_d = DONE;
            end else begin
                p_d     = '0;
                qacc_d  = '0;
                cnt_d   = CNT_W'(W - 1);
                state_d = CALC;
            end
        end
    end

    // Handshake flags are registered from the next state.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.check_err   = err_q;

endmodule

// File: tb/tb_divu4_seq_chk.sv
// Directed self-checking bench for divu4_seq_chk (CHECK_EN=1, ZERO_QUOT=4'hF).
module tb_divu4_seq_chk;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    divu4_seq_chk_if bus ();

    divu4_seq_chk #(
        .CHECK_EN  (1'b1),
        .ZERO_QUOT (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive a request at the current negedge; returns at the negedge after acceptance.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // Count negedges until done; bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 000",
                     {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        start_op(4'd13, 4'd3);
        wait_done(n);
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d expected 5", n);
        end
        vectors++;
        if ({bus.busy, bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err} !== {1'b1, 4'd4, 4'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_13_3: got busy/q/r/dbz/err %b/%0d/%0d/%b/%b expected 1/4/1/0/0",
                     bus.busy, bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err);
        end
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder} !== {1'b0, 1'b0, 4'd4, 4'd1}) begin
            miscompares++;
            $display("FAIL basic_hold: got busy/done/q/r %b/%b/%0d/%0d expected 0/0/4/1",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(4'd15, 4'd1);
        wait_done(n);
        vectors++;
        if (n !== 5 || bus.quotient !== 4'd15 || bus.remainder !== 4'd0) begin
            miscompares++;
            $display("FAIL b2b_first: got lat/q/r %0d/%0d/%0d expected 5/15/0", n, bus.quotient, bus.remainder);
        end
        start_op(4'd2, 4'd9);
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_gap: got busy/done %b/%b expected 1/0", bus.busy, bus.done);
        end
        wait_done(n);
        vectors++;
        if (n !== 5 || bus.quotient !== 4'd0 || bus.remainder !== 4'd2 || bus.check_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got lat/q/r/err %0d/%0d/%0d/%b expected 5/0/2/0",
                     n, bus.quotient, bus.remainder, bus.check_err);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int n;
        start_op(4'd7, 4'd0);
        wait_done(n);
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL dbz_latency: got %0d expected 0", n);
        end
        vectors++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err} !== {4'hF, 4'd7, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL dbz_7_0: got q/r/dbz/err %h/%0d/%b/%b expected f/7/1/0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err);
        end
        @(negedge clk);
        vectors++;
        if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_hold: got dbz/done %b/%b expected 1/0", bus.div_by_zero, bus.done);
        end
    endtask

    task automatic test_ignored_start();
        int n;
        start_op(4'd9, 4'd2);
        vectors++;
        if (bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_flag_clear: got dbz %b expected 0", bus.div_by_zero);
        end
        @(negedge clk);
        bus.dividend = 4'd1;
        bus.divisor  = 4'd1;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(n);
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL ign_latency: got %0d expected 3", n);
        end
        vectors++;
        if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1 || bus.check_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_9_2: got q/r/err %0d/%0d/%b expected 4/1/0", bus.quotient, bus.remainder, bus.check_err);
        end
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_no_queue: got busy %b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int  n;
        bit  seen;
        start_op(4'd11, 4'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err} !== 12'h000) begin
            miscompares++;
            $display("FAIL abort_zeroed: got %h expected 000",
                     {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err});
        end
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: got activity %b expected 0", seen);
        end
        start_op(4'd12, 4'd4);
        wait_done(n);
        vectors++;
        if (n !== 5 || bus.quotient !== 4'd3 || bus.remainder !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_fresh_12_4: got lat/q/r %0d/%0d/%0d expected 5/3/0", n, bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_fault_check();
        start_op(4'd8, 4'd2);
        repeat (4) @(negedge clk);
        force dut.rem_q = 4'd1;
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b1 || bus.check_err !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_check_err: got done/err %b/%b expected 1/1", bus.done, bus.check_err);
        end
        release dut.rem_q;
        @(negedge clk);
        start_op(4'd6, 4'd3);
        vectors++;
        if (bus.check_err !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_err_clear: got err %b expected 0", bus.check_err);
        end
        begin
            int n;
            wait_done(n);
            vectors++;
            if (n !== 5 || bus.quotient !== 4'd2 || bus.remainder !== 4'd0 || bus.check_err !== 1'b0) begin
                miscompares++;
                $display("FAIL fault_recover_6_3: got lat/q/r/err %0d/%0d/%0d/%b expected 5/2/0/0",
                         n, bus.quotient, bus.remainder, bus.check_err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        int          n;
        int          exp_lat;
        logic [3:0]  eq, er;
        logic        edbz;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 4'hF; er = 4'(a); edbz = 1'b1; exp_lat = 0;
                end else begin
                    eq = 4'(a / b); er = 4'(a % b); edbz = 1'b0; exp_lat = 5;
                end
                start_op(4'(a), 4'(b));
                wait_done(n);
                vectors++;
                if (n !== exp_lat || {bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err} !== {eq, er, edbz, 1'b0}) begin
                    miscompares++;
                    $display("FAIL sweep_%0d_%0d: got lat/q/r/dbz/err %0d/%0d/%0d/%b/%b expected %0d/%0d/%0d/%b/0",
                             a, b, n, bus.quotient, bus.remainder, bus.div_by_zero, bus.check_err,
                             exp_lat, eq, er, edbz);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignored_start();
        test_reset_abort();
        test_fault_check();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
